// File: rtl/apb_bridge_gen2_if.sv
// AHB-Lite slave side and APB master side of the bridge gathered into one bundle.
// The bridge connects through "slave"; the surrounding system drives through "master".
interface apb_bridge_gen2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLOTS  = 16
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [3:0]            HPROT;
  logic [31:0]           HWDATA;
  logic                  HREADYIN;
  logic                  HREADYOUT;
  logic [31:0]           HRDATA;
  logic                  HRESP;

  logic [NUM_SLOTS-1:0]  PSEL;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic                  PENABLE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HPROT, HWDATA, HREADYIN,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRDATA, HRESP,
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HPROT, HWDATA, HREADYIN,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRDATA, HRESP,
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_bridge_gen2.sv
// AHB-Lite to APB bridge: one transfer at a time, slot decoded from a 4-bit address
// field, APB wait timeout, and the AHB two-cycle ERROR response.
module apb_bridge_gen2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLOTS  = 16,
  parameter int SLOT_LSB   = 24,
  parameter bit APB4       = 1'b1,
  parameter int TIMEOUT    = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  apb_bridge_gen2_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  logic [3:0]            slot_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [1:0]            prot_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         wait_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [31:0]           pwdata_q;
  logic [3:0]            pstrb_q;
  logic [2:0]            pprot_q;
  logic [31:0]           hrdata_q;

  logic                  ready_state;
  logic                  accept;
  logic [3:0]            slot_in;
  logic                  bad_in;
  logic                  from_wdata;
  logic [ADDR_WIDTH-1:0] setup_addr;
  logic                  setup_write;
  logic [2:0]            setup_size;
  logic [1:0]            setup_prot;
  logic                  timed_out;

  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    return 4'b0001 << a;
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Only states that present HREADYOUT=1 may take a new address phase.
  assign ready_state = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR2);
  assign accept      = ready_state && bus.HSEL && bus.HREADYIN && bus.HTRANS[1];
  assign slot_in     = bus.HADDR[SLOT_LSB+3:SLOT_LSB];
  assign bad_in      = ({1'b0, slot_in} >= 5'(NUM_SLOTS)) || (bus.HSIZE > 3'd2);
  assign timed_out   = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // Reads go straight to SETUP from the live address phase; writes come via WDATA.
  assign from_wdata  = (state_q == WDATA);
  assign setup_addr  = from_wdata ? addr_q  : bus.HADDR;
  assign setup_write = from_wdata ? write_q : bus.HWRITE;
  assign setup_size  = from_wdata ? size_q  : bus.HSIZE;
  assign setup_prot  = from_wdata ? prot_q  : bus.HPROT[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR2: begin
        if (!accept)          state_d = IDLE;
        else if (bad_in)      state_d = ERR1;
        else if (bus.HWRITE)  state_d = WDATA;
        else                  state_d = SETUP;
      end
      WDATA:  state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY)       state_d = bus.PSLVERR ? ERR1 : DONE;
        else if (timed_out)   state_d = ERR1;
      end
      ERR1:   state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.HREADYOUT = ready_state;
    bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
    bus.PSEL      = '0;
    if ((state_q == SETUP) || (state_q == ACCESS))
      bus.PSEL = NUM_SLOTS'(1) << slot_q;
    bus.PENABLE   = (state_q == ACCESS);
    bus.HRDATA    = hrdata_q;
    bus.PADDR     = paddr_q;
    bus.PWRITE    = pwrite_q;
    bus.PWDATA    = pwdata_q;
    bus.PSTRB     = APB4 ? pstrb_q : 4'b0000;
    bus.PPROT     = APB4 ? pprot_q : 3'b000;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      prot_q   <= '0;
      addr_q   <= '0;
      wait_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        slot_q  <= slot_in;
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
        prot_q  <= bus.HPROT[1:0];
        addr_q  <= bus.HADDR;
      end
      if (state_q == WDATA)
        pwdata_q <= bus.HWDATA;
      // APB address-side fields change only when a real APB cycle starts.
      if (state_d == SETUP) begin
        wait_q   <= '0;
        paddr_q  <= setup_addr;
        pwrite_q <= setup_write;
        pstrb_q  <= setup_write ? strb_of(setup_size, setup_addr[1:0]) : 4'b0000;
        pprot_q  <= {~setup_prot[0], 1'b0, setup_prot[1]};
      end else if ((state_q == ACCESS) && !bus.PREADY) begin
        wait_q <= wait_q + 1'b1;
      end
      if ((state_q == ACCESS) && bus.PREADY && !bus.PSLVERR && !write_q)
        hrdata_q <= bus.PRDATA;
    end
  end

endmodule

// File: tb/tb_apb_bridge_gen2.sv
// Directed plus randomized transfers against a per-cycle expected trace built from the
// bridge's handshake rules (latency, wait/timeout, slot decode, error response).
module tb_apb_bridge_gen2;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int TO = 8;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  apb_bridge_gen2_if #(.ADDR_WIDTH(AW), .NUM_SLOTS(NS)) bus ();

  apb_bridge_gen2 #(
    .ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_LSB(24), .APB4(1'b1), .TIMEOUT(TO)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          hready;
    logic          hresp;
    logic [NS-1:0] psel;
    logic          pen;
    logic          pready;
  } cyc_t;

  cyc_t        trace[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = '0;

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One AHB transfer with the given APB slave behaviour; every cycle is compared.
  task automatic apply_stimulus(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                input logic [3:0] prot, input logic [31:0] wdata, input int waits,
                                input logic slverr, input logic [31:0] rdata);
    int            slot;
    bit            legal, ok_end;
    int            n_acc, nbytes, base;
    logic [NS-1:0] onehot;
    logic [3:0]    strb_exp;
    logic [2:0]    pprot_exp;
    slot   = int'(addr[27:24]);
    legal  = (slot < NS) && (size <= 3'd2);
    onehot = '0;
    if (slot < NS) onehot[slot] = 1'b1;
    strb_exp = '0;
    if (legal && write) begin
      nbytes = 1 << size;
      base   = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
      for (int i = 0; i < 4; i++) strb_exp[i] = (i >= base) && (i < base + nbytes);
    end
    pprot_exp = {~prot[0], 1'b0, prot[1]};

    trace.delete();
    ok_end = 0;
    if (!legal) begin
      trace.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b0});
      trace.push_back('{1'b1, 1'b1, '0, 1'b0, 1'b0});
    end else begin
      if (write) trace.push_back('{1'b0, 1'b0, '0, 1'b0, 1'b0});
      trace.push_back('{1'b0, 1'b0, onehot, 1'b0, 1'b0});
      ok_end = (waits < TO);
      n_acc  = ok_end ? waits + 1 : TO;
      for (int i = 0; i < n_acc; i++)
        trace.push_back('{1'b0, 1'b0, onehot, 1'b1, logic'(ok_end && (i == waits))});
      if (ok_end && !slverr) begin
        trace.push_back('{1'b1, 1'b0, '0, 1'b0, 1'b0});
      end else begin
        trace.push_back('{1'b0, 1'b1, '0, 1'b0, 1'b0});
        trace.push_back('{1'b1, 1'b1, '0, 1'b0, 1'b0});
      end
    end

    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = write;
    bus.HSIZE = size; bus.HPROT = prot; bus.HREADYIN = 1'b1;
    check_output("addr_phase_ready", {bus.HREADYOUT, bus.HRESP}, 2'b10);
    @(posedge HCLK);
    @(negedge HCLK);
    for (int k = 0; k < trace.size(); k++) begin
      bus.HWDATA = (k == 0) ? wdata : $urandom;
      // A competing request while the bridge stalls must be ignored.
      if (!trace[k].hready) begin
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = $urandom; bus.HWRITE = 1'($urandom);
      end else begin
        bus.HSEL = 1'($urandom); bus.HTRANS = 2'b00;
      end
      bus.PREADY  = trace[k].pready;
      bus.PSLVERR = slverr;
      bus.PRDATA  = trace[k].pready ? rdata : $urandom;
      #1;
      check_output($sformatf("cycle%0d", k),
                   {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE},
                   {trace[k].hready, trace[k].hresp, trace[k].psel, trace[k].pen});
      if (trace[k].psel != '0)
        check_output($sformatf("apb_fields%0d", k),
                     {bus.PADDR, bus.PWRITE, bus.PSTRB, bus.PPROT},
                     {addr, write, strb_exp, pprot_exp});
      if ((trace[k].psel != '0) && write)
        check_output($sformatf("pwdata%0d", k), bus.PWDATA, wdata);
      if (k == trace.size() - 1) begin
        if (legal && !write && ok_end && !slverr) last_rdata = rdata;
        check_output("hrdata", bus.HRDATA, last_rdata);
      end
      @(posedge HCLK);
      @(negedge HCLK);
    end
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          slot;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00; bus.HSIZE = '0;
    bus.HPROT = '0; bus.HWDATA = '0; bus.HREADYIN = 1'b1;
    bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_output("reset_state",
                 {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR,
                  bus.PWDATA, bus.PSTRB, bus.PPROT, bus.HRDATA},
                 {1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0, 32'h0});
    HRESET = 1'b0;

    // Idle, busy and unselected cycles answer with zero wait and no APB activity.
    for (int i = 0; i < 3; i++) begin
      bus.HSEL   = (i != 2);
      bus.HTRANS = (i == 0) ? 2'b00 : ((i == 1) ? 2'b01 : 2'b10);
      bus.HADDR  = 32'h0100_0000;
      @(posedge HCLK);
      @(negedge HCLK);
      check_output($sformatf("no_xfer%0d", i), {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE},
                   {1'b1, 1'b0, 4'b0, 1'b0});
    end
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;

    $display("[TB] directed transfers");
    apply_stimulus(32'h0300_0010, 1'b0, 3'd2, 4'b0011, 32'h0, 0, 1'b0, 32'hDEADBEEF);
    apply_stimulus(32'h0100_0002, 1'b1, 3'd0, 4'b0001, 32'h00AA_0000, 0, 1'b0, 32'h0);
    apply_stimulus(32'h0200_0020, 1'b0, 3'd2, 4'b0010, 32'h0, 5, 1'b1, 32'h1234_5678);
    apply_stimulus(32'h0000_0040, 1'b1, 3'd2, 4'b0000, 32'hCAFE_F00D, 20, 1'b0, 32'h0);
    apply_stimulus(32'h0500_0000, 1'b0, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 32'h5555_5555);
    apply_stimulus(32'h0100_0000, 1'b1, 3'd3, 4'b0000, 32'h1111_1111, 0, 1'b0, 32'h0);
    apply_stimulus(32'h0300_0102, 1'b1, 3'd1, 4'b0011, 32'hBEEF_0000, 2, 1'b0, 32'h0);
    apply_stimulus(32'h0200_0004, 1'b0, 3'd2, 4'b0001, 32'h0, 7, 1'b0, 32'hA5A5_0F0F);

    $display("[TB] reset during ACCESS");
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0200_0008; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd2; bus.HPROT = 4'b0; bus.PREADY = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_output("pre_reset_access", {bus.PSEL, bus.PENABLE}, {4'b0100, 1'b1});
    HRESET = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    check_output("post_reset",
                 {bus.HREADYOUT, bus.HRESP, bus.PSEL, bus.PENABLE, bus.PADDR, bus.HRDATA},
                 {1'b1, 1'b0, 4'b0, 1'b0, 32'h0, 32'h0});
    last_rdata = '0;
    @(posedge HCLK);
    @(negedge HCLK);
    check_output("post_reset_idle", {bus.HREADYOUT, bus.PSEL, bus.PENABLE}, {1'b1, 4'b0, 1'b0});
    apply_stimulus(32'h0300_0010, 1'b0, 3'd2, 4'b0000, 32'h0, 1, 1'b0, 32'h0BAD_F00D);

    $display("[TB] random transfers");
    for (int n = 0; n < 60; n++) begin
      slot = $urandom_range(0, 5);
      sz   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a    = $urandom;
      a[27:24] = 4'(slot);
      if (sz == 3'd1) a[0] = 1'b0;
      if (sz >= 3'd2) a[1:0] = 2'b00;
      apply_stimulus(a, 1'($urandom), sz, 4'($urandom), $urandom,
                     $urandom_range(0, 10), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
